// File: rtl/timer_tima.sv
// TIMA/TMA/TAC timer for the FF05-FF07 window: counts falling edges of the
// selected divider tap and reloads TIMA from TMA one cycle after overflow.
module timer_tima (
  input  logic       boga1mhz,
  input  logic       reset,
  inout  wire  [7:0] d,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       ff04_ff07,
  input  logic       tovy_na0,
  input  logic       tola_na1,
  input  logic [3:0] div_taps,
  output logic       int_timer
);

  typedef enum logic [1:0] {RUN, OVF, RELOAD} state_e;

  state_e      state_q;
  logic [7:0]  tima_q;
  logic [7:0]  tma_q;
  logic [2:0]  tac_q;
  logic        sel_q;
  logic        int_q;

  logic        sel_tima;
  logic        sel_tma;
  logic        sel_tac;
  logic        sel_d;
  logic        inc;
  logic        wr_tima;
  logic        wr_tma;
  logic        wr_tac;
  logic [8:0]  tima_inc_d;
  logic [7:0]  rd_data;

  always_comb begin
    sel_tima   = ff04_ff07 &  tola_na1 & ~tovy_na0;
    sel_tma    = ff04_ff07 & ~tola_na1 &  tovy_na0;
    sel_tac    = ff04_ff07 & ~tola_na1 & ~tovy_na0;
    wr_tima    = cpu_wr & sel_tima;
    wr_tma     = cpu_wr & sel_tma;
    wr_tac     = cpu_wr & sel_tac;
    sel_d      = tac_q[2] & div_taps[tac_q[1:0]];
    inc        = sel_q & ~sel_d;
    tima_inc_d = {1'b0, tima_q} + 9'd1;
  end

  always_comb begin
    rd_data = '0;
    if (sel_tima)     rd_data = tima_q;
    else if (sel_tma) rd_data = tma_q;
    else if (sel_tac) rd_data = {5'b11111, tac_q};
  end

  assign d         = (cpu_rd && (sel_tima || sel_tma || sel_tac)) ? rd_data : 'z;
  assign int_timer = int_q;

  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      tima_q  <= '0;
      tma_q   <= '0;
      tac_q   <= '0;
      sel_q   <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      sel_q <= sel_d;
      int_q <= 1'b0;
      if (wr_tma) tma_q <= d;
      if (wr_tac) tac_q <= d[2:0];
      case (state_q)
        RUN: begin
          if (wr_tima) begin
            tima_q <= d;
          end else if (inc) begin
            tima_q <= tima_inc_d[7:0];
            if (tima_inc_d[8]) state_q <= OVF;
          end
        end
        // A TIMA write here cancels the pending reload; an increment of the
        // 0x00 value is overwritten by the reload on the same edge.
        OVF: begin
          if (wr_tima) begin
            tima_q  <= d;
            state_q <= RUN;
          end else begin
            tima_q  <= tma_q;
            int_q   <= 1'b1;
            state_q <= RELOAD;
          end
        end
        RELOAD: begin
          if (wr_tma) tima_q <= d;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_tima.sv
// Randomized and directed bench for timer_tima against a cycle-level model
// of the TIMA/TMA/TAC register behaviour.
module tb_timer_tima;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       ff04_ff07 = 1'b1;
  logic       tovy_na0 = 1'b1;
  logic       tola_na1 = 1'b1;
  logic [3:0] div_taps = 4'h0;
  logic       int_timer;
  logic [7:0] tb_d = 8'h00;
  logic       tb_drv = 1'b0;
  wire  [7:0] d_bus;

  int checks = 0;
  int errors = 0;

  // Model state
  int         m_tima, m_tma, m_tac;
  bit         m_psel;
  int         m_phase;   // 0 counting, 1 just overflowed, 2 reload cycle
  bit         m_int;

  assign d_bus = tb_drv ? tb_d : 'z;

  always #5 clk = ~clk;

  timer_tima dut (
    .boga1mhz (clk),
    .reset    (reset),
    .d        (d_bus),
    .cpu_wr   (cpu_wr),
    .cpu_rd   (cpu_rd),
    .ff04_ff07(ff04_ff07),
    .tovy_na0 (tovy_na0),
    .tola_na1 (tola_na1),
    .div_taps (div_taps),
    .int_timer(int_timer)
  );

  // r: 0 FF04, 1 TIMA, 2 TMA, 3 TAC
  task automatic set_addr(input int r);
    ff04_ff07 = 1'b1;
    case (r)
      1: begin tola_na1 = 1'b1; tovy_na0 = 1'b0; end
      2: begin tola_na1 = 1'b0; tovy_na0 = 1'b1; end
      3: begin tola_na1 = 1'b0; tovy_na0 = 1'b0; end
      default: begin tola_na1 = 1'b1; tovy_na0 = 1'b1; end
    endcase
  endtask

  task automatic m_reset();
    m_tima = 0; m_tma = 0; m_tac = 0; m_psel = 0; m_phase = 0; m_int = 0;
  endtask

  task automatic model_step(input bit wr, input int r, input int data, input logic [3:0] taps);
    bit sel, inc, wt, wm, wc;
    sel = (m_tac >= 4) && taps[m_tac % 4];
    inc = m_psel && !sel;
    wt = wr && r == 1; wm = wr && r == 2; wc = wr && r == 3;
    m_int = 0;
    if (m_phase == 1) begin
      if (wt) begin m_tima = data; m_phase = 0; end
      else begin m_tima = m_tma; m_int = 1; m_phase = 2; end
    end else if (m_phase == 2) begin
      if (wm) m_tima = data;
      m_phase = 0;
    end else if (wt) begin
      m_tima = data;
    end else if (inc) begin
      m_tima = (m_tima + 1) % 256;
      if (m_tima == 0) m_phase = 1;
    end
    if (wm) m_tma = data;
    if (wc) m_tac = data % 8;
    m_psel = sel;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit wr, input int r, input logic [7:0] data, input logic [3:0] taps);
    div_taps = taps;
    set_addr(r);
    tb_d = data;
    tb_drv = wr;
    cpu_rd = 1'b0;
    cpu_wr = wr;
    @(posedge clk);
    model_step(wr, r, int'(data), taps);
    @(negedge clk);
    cpu_wr = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic rd(input int r, output logic [7:0] v);
    tb_drv = 1'b0;
    set_addr(r);
    cpu_rd = 1'b1;
    #1 v = d_bus;
    cpu_rd = 1'b0;
  endtask

  task automatic setup_ovf(input logic [7:0] tma_val);
    step(1, 3, 8'h05, 4'h0);
    step(1, 2, tma_val, 4'h0);
    step(1, 1, 8'hFE, 4'h0);
    step(0, 0, 8'h00, 4'h2);
    step(0, 0, 8'h00, 4'h0);
    step(0, 0, 8'h00, 4'h2);
    step(0, 0, 8'h00, 4'h0);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tima got %h exp 00", v); end
    rd(2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tma got %h exp 00", v); end
    rd(3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL reset_tac got %h exp f8", v); end
    checks++;
    if (int_timer !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", int_timer); end
    set_addr(3); cpu_rd = 1'b0; tb_d = 8'h00; tb_drv = 1'b1;
    #1 checks++;
    if (d_bus !== 8'h00) begin errors++; $display("FAIL idle_bus_released got %h exp 00", d_bus); end
    set_addr(0); cpu_rd = 1'b1;
    #1 checks++;
    if (d_bus !== 8'h00) begin errors++; $display("FAIL ff04_not_driven got %h exp 00", d_bus); end
    cpu_rd = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    step(1, 3, 8'h05, 4'h0);
    step(1, 2, 8'h42, 4'h0);
    step(1, 1, 8'hFE, 4'h0);
    step(0, 0, 8'h00, 4'h2);
    rd(1, v); checks++;
    if (v !== 8'hFE) begin errors++; $display("FAIL ovf_no_inc_on_rise got %h exp fe", v); end
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL ovf_first_inc got %h exp ff", v); end
    step(0, 0, 8'h00, 4'h2);
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h00 || int_timer !== 1'b0) begin
      errors++; $display("FAIL ovf_cycle got tima %h int %b exp 00 0", v, int_timer);
    end
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h42 || int_timer !== 1'b1) begin
      errors++; $display("FAIL reload_cycle got tima %h int %b exp 42 1", v, int_timer);
    end
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h42 || int_timer !== 1'b0) begin
      errors++; $display("FAIL after_reload got tima %h int %b exp 42 0", v, int_timer);
    end
  endtask

  task automatic test_ovf_write();
    logic [7:0] v;
    int pulses = 0;
    setup_ovf(8'h42);
    step(1, 1, 8'h10, 4'h0);
    pulses += int'(int_timer);
    repeat (2) begin step(0, 0, 8'h00, 4'h0); pulses += int'(int_timer); end
    rd(1, v); checks++;
    if (v !== 8'h10 || pulses != 0) begin
      errors++; $display("FAIL ovf_write_cancels got tima %h pulses %0d exp 10 0", v, pulses);
    end
    setup_ovf(8'h42);
    step(0, 0, 8'h00, 4'h0);
    step(1, 1, 8'h10, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL reload_tima_write_ignored got %h exp 42", v); end
  endtask

  task automatic test_reload_tma();
    logic [7:0] v;
    int pulses = 0;
    setup_ovf(8'h42);
    step(0, 0, 8'h00, 4'h0); pulses += int'(int_timer);
    step(1, 2, 8'h77, 4'h0); pulses += int'(int_timer);
    repeat (2) begin step(0, 0, 8'h00, 4'h0); pulses += int'(int_timer); end
    rd(1, v); checks++;
    if (v !== 8'h77 || pulses != 1) begin
      errors++; $display("FAIL reload_tma_write got tima %h pulses %0d exp 77 1", v, pulses);
    end
  endtask

  task automatic test_disable_glitch();
    logic [7:0] v;
    step(1, 3, 8'h07, 4'h8);
    step(1, 1, 8'h20, 4'h8);
    step(1, 3, 8'h03, 4'h8);
    step(0, 0, 8'h00, 4'h8);
    step(0, 0, 8'h00, 4'h8);
    rd(1, v); checks++;
    if (v !== 8'h21) begin errors++; $display("FAIL disable_glitch_high got %h exp 21", v); end
    step(1, 3, 8'h07, 4'h0);
    step(1, 1, 8'h20, 4'h0);
    step(1, 3, 8'h03, 4'h0);
    step(0, 0, 8'h00, 4'h0);
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL disable_glitch_low got %h exp 20", v); end
  endtask

  task automatic test_write_priority();
    logic [7:0] v;
    step(1, 3, 8'h05, 4'h2);
    step(1, 1, 8'h30, 4'h2);
    step(0, 0, 8'h00, 4'h2);
    step(1, 1, 8'h80, 4'h0);
    step(0, 0, 8'h00, 4'h0);
    rd(1, v); checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL write_beats_inc got %h exp 80", v); end
  endtask

  task automatic test_reset_ovf();
    logic [7:0] v;
    int pulses = 0;
    setup_ovf(8'h42);
    reset = 1'b1;
    #1 rd(1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL async_reset_tima got %h exp 00", v); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    pulses += int'(int_timer);
    repeat (4) begin step(0, 0, 8'h00, 4'h0); pulses += int'(int_timer); end
    rd(1, v); checks++;
    if (v !== 8'h00 || pulses != 0) begin
      errors++; $display("FAIL reset_in_ovf got tima %h pulses %0d exp 00 0", v, pulses);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] data;
    bit prev_int = 0;
    for (int i = 0; i < 1500; i++) begin
      bit wr;
      int r;
      wr = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 3);
      data = 8'($urandom);
      if (r == 1 && $urandom_range(0, 1) == 1) data = data | 8'hF0;
      if (r == 3 && $urandom_range(0, 3) != 0) data = data | 8'h04;
      step(wr, r, data, 4'($urandom));
      checks++;
      if (int_timer !== m_int) begin
        errors++; $display("FAIL rand_int cyc %0d got %b exp %b", i, int_timer, m_int);
      end
      checks++;
      if (int_timer === 1'b1 && prev_int) begin
        errors++; $display("FAIL rand_int_back_to_back cyc %0d got 1 exp 0", i);
      end
      prev_int = (int_timer === 1'b1);
      rd(1, v); checks++;
      if (v !== 8'(m_tima)) begin
        errors++; $display("FAIL rand_tima cyc %0d got %h exp %h", i, v, 8'(m_tima));
      end
      if (i % 16 == 0) begin
        rd(2, v); checks++;
        if (v !== 8'(m_tma)) begin
          errors++; $display("FAIL rand_tma cyc %0d got %h exp %h", i, v, 8'(m_tma));
        end
        rd(3, v); checks++;
        if (v !== (8'hF8 | 8'(m_tac))) begin
          errors++; $display("FAIL rand_tac cyc %0d got %h exp %h", i, v, 8'hF8 | 8'(m_tac));
        end
      end
    end
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    test_reset();
    test_overflow();
    test_ovf_write();
    test_reload_tma();
    test_disable_glitch();
    test_write_priority();
    test_reset_ovf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
